// File: rtl/core_types_pkg.sv
// Shared fetch-predictor parameters (return address stack sizing and reset fill value).
package core_types_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_TARGET_WIDTH = 31;
  localparam logic [31:0] INIT_PC          = 32'h8000_0000;

  // Entries store PC[31:1]; the halfword bit is implied.
  localparam logic [RAS_TARGET_WIDTH-1:0] RAS_INIT_TARGET = INIT_PC[31:1];

endpackage

// File: rtl/ras.sv
// Return address stack: push on predicted call, pop on predicted return,
// (index, count) checkpoint exported each cycle and restorable on mispredict.
module ras
  import core_types_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        link_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] link_target,
  input  logic                        ret_valid,
  output logic [RAS_TARGET_WIDTH-1:0] ras_target,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_INDEX_WIDTH:0]    ras_count,
  input  logic                        update_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_ras_index,
  input  logic [RAS_INDEX_WIDTH:0]    update_ras_count
);

  localparam logic [RAS_INDEX_WIDTH:0] CountMax = (RAS_INDEX_WIDTH+1)'(RAS_ENTRIES);

  logic [RAS_TARGET_WIDTH-1:0] stack_q [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
  logic [RAS_INDEX_WIDTH:0]    count_q, count_d;
  logic                        wr_en;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    if (update_valid) begin
      ptr_d   = update_ras_index;
      count_d = (update_ras_count > CountMax) ? CountMax : update_ras_count;
    end else if (link_valid && ret_valid) begin
      // Pop then push collapses to overwriting the current top in place.
      wr_en = 1'b1;
    end else if (link_valid) begin
      ptr_d   = ptr_q + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = ptr_q + 1'b1;
      count_d = (count_q == CountMax) ? CountMax : count_q + 1'b1;
    end else if (ret_valid) begin
      ptr_d   = ptr_q - 1'b1;
      count_d = (count_q == '0) ? '0 : count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < RAS_ENTRIES; i++) stack_q[i] <= RAS_INIT_TARGET;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) stack_q[wr_idx] <= link_target;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign ras_target = stack_q[ptr_q];
  assign ras_index  = ptr_q;
  assign ras_count  = count_q;

endmodule
